temperature_monitor: RTL and testbench
======================================

// Module: temperature_monitor
// PURPOSE
//  Downstream consumer of the temperature calculator's 32-bit tempc result.
//  Registers each valid sample and keeps a moving average over 2**AVG_LOG2 samples.
//  Classifies the average against programmable high/low thresholds with hysteresis
//  and debounce, and drives alarm flags plus a state code for the system controller.
// PARAMETERS
//  AVG_LOG2  2  log2 of moving-average window (window = 4 samples); legal 0..4
//  DEBOUNCE  3  consecutive qualifying averages needed to change alarm state; legal 1..15
//  HYST      2  hysteresis in tempc LSBs applied when leaving an alarm state
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  tm_valid    in   1   tm_tempc holds a new sample this cycle
//  tm_tempc    in   32  signed two's-complement temperature from the calculator stage
//  thr_high    in   32  signed high threshold, sampled on each avg update
//  thr_low     in   32  signed low threshold, sampled on each avg update
//  avg_valid   out  1   one-cycle pulse: avg_tempc updated
//  avg_tempc   out  32  signed moving average
//  alarm_high  out  1   1 while state == HIGH
//  alarm_low   out  1   1 while state == LOW
//  tm_state    out  2   00 NORMAL, 01 HIGH, 10 LOW, 11 unused (never driven)
// BEHAVIOUR
//  Reset: all outputs 0; ring buffer, sum, fill count, debounce count = 0; state NORMAL.
//  Window: ring buffer of 2**AVG_LOG2 x 32b, write pointer wraps modulo window size.
//  - Each tm_valid: sum <= sum + tm_tempc - oldest; write tm_tempc over oldest; ptr++.
//  - sum is signed, 32+AVG_LOG2 bits; no overflow possible.
//  - avg = sum >>> AVG_LOG2 (arithmetic shift; truncates toward -inf).
//  - avg_valid/avg_tempc are suppressed until the window has filled once.
//    First pulse comes on the cycle after the 2**AVG_LOG2-th tm_valid.
//    After that, one pulse per tm_valid, latency 1 clk.
//  - Back-to-back tm_valid on consecutive cycles is legal; throughput 1 sample/clk.
//  Alarm FSM, evaluated only in the cycle avg_valid is high, using that avg_tempc:
//  - NORMAL: if avg > thr_high, hi_cnt++, else hi_cnt=0.
//    If avg < thr_low, lo_cnt++, else lo_cnt=0.
//    If hi_cnt reaches DEBOUNCE -> HIGH. Else if lo_cnt reaches DEBOUNCE -> LOW.
//    If both qualify in one update, HIGH wins and lo_cnt is cleared.
//  - HIGH: exit_cnt++ when avg < thr_high - HYST, else exit_cnt=0.
//    At DEBOUNCE -> NORMAL. No direct HIGH->LOW transition.
//  - LOW: exit_cnt++ when avg > thr_low + HYST, else exit_cnt=0.
//    At DEBOUNCE -> NORMAL.
//  - Every state change clears all counters. Comparisons are signed 32-bit.
//    Threshold +/- HYST saturates at the signed 32-bit limits.
//  - Counters saturate at DEBOUNCE. Counters and state change only on avg_valid.
//  - alarm_high, alarm_low and tm_state are registered; they update on the same edge
//    the state register changes, 1 clk after the qualifying avg_valid.
//  Misconfiguration thr_low >= thr_high is legal; the HIGH priority rule above applies.
//  Reset mid-operation: immediate return to reset values; the window must refill.
// CONFIGURATION
//  TEMP_MINMAX_EN defined: adds ports
//    clr_minmax  in   1
//    tmin        out  32  signed
//    tmax        out  32  signed
//  - Tracks min/max of avg_tempc since reset or clr_minmax.
//  - First avg after reset/clear loads both.
//  - clr_minmax together with avg_valid: clear, then that avg loads both.
//  - Reset value of tmin/tmax is 0.
//  TEMP_MINMAX_EN undefined: ports and logic absent; all other behaviour identical.
// TESTING
//  1. Reset, then 4 samples of 100 -> no avg_valid after samples 1-3;
//     avg_valid 1 clk after sample 4 with avg_tempc=100.
//  2. Window of 100, then one sample of 104 -> avg_tempc=101.
//     Samples -1,-2,-3,-4 after reset -> avg_tempc=-3 (arithmetic floor of -2.5).
//  3. thr_high=50, thr_low=-50, avgs 51,51,51 -> alarm_high rises after 3rd avg_valid.
//     Sequence 51,51,49,51 keeps NORMAL.
//  4. In HIGH with thr_high=50: avgs 49,49,49 stay HIGH.
//     Three avgs of 47 -> NORMAL, alarm_high=0.
//  5. thr_high=0, thr_low=10, avg 5 x3 -> HIGH (priority), alarm_low never set.
//     Assert rst_n low mid-run -> all outputs 0 asynchronously.
//  6. TEMP_MINMAX_EN: avgs 10,-20,30 -> tmin=-20, tmax=30.
//     clr_minmax with avg 5 -> tmin=tmax=5.

Source files
------------

// File: rtl/temperature_monitor.sv
// Moving-average temperature monitor with debounced high/low alarm FSM and hysteresis.
// Optional min/max tracking of the average is enabled by defining TEMP_MINMAX_EN.
module temperature_monitor #(
    parameter int AVG_LOG2 = 2,
    parameter int DEBOUNCE = 3,
    parameter int HYST     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tm_valid,
    input  logic signed [31:0] tm_tempc,
    input  logic signed [31:0] thr_high,
    input  logic signed [31:0] thr_low,
    output logic               avg_valid,
    output logic signed [31:0] avg_tempc,
    output logic               alarm_high,
    output logic               alarm_low,
    output logic [1:0]         tm_state
`ifdef TEMP_MINMAX_EN
    ,
    input  logic               clr_minmax,
    output logic signed [31:0] tmin,
    output logic signed [31:0] tmax
`endif
);

    localparam int WIN  = 1 << AVG_LOG2;
    localparam int SUMW = 32 + AVG_LOG2;
    localparam int PTRW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [3:0]         DEB_C  = 4'(DEBOUNCE);
    localparam logic signed [32:0] HYST_S = 33'(HYST);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_HIGH   = 2'b01,
        ST_LOW    = 2'b10
    } state_t;

    // Threshold offset clamped to the signed 32-bit range so extreme thresholds never wrap.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [32:0] b);
        logic signed [33:0] s;
        s = 34'(a) + 34'(b);
        if (s > 34'sh0_7FFF_FFFF) begin
            return 32'sh7FFF_FFFF;
        end else if (s < -34'sh0_8000_0000) begin
            return 32'sh8000_0000;
        end else begin
            return s[31:0];
        end
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= DEB_C) ? DEB_C : c + 4'd1;
    endfunction

    logic signed [31:0]     ring_r [WIN];
    logic [PTRW-1:0]        ptr_r;
    logic                   filled_r;
    logic signed [SUMW-1:0] sum_r;
    logic signed [SUMW-1:0] sum_nxt_s;
    logic                   last_slot_s;
    logic                   avg_upd_s;

    state_t             state_r, state_nxt_s;
    logic [3:0]         hi_cnt_r, lo_cnt_r, ex_cnt_r;
    logic [3:0]         hi_cnt_nxt_s, lo_cnt_nxt_s, ex_cnt_nxt_s;
    logic signed [31:0] hi_exit_s, lo_exit_s;

    // Running sum update and window-fill detection.
    always_comb begin
        sum_nxt_s   = sum_r + SUMW'(tm_tempc) - SUMW'(ring_r[ptr_r]);
        last_slot_s = (ptr_r == PTRW'(WIN - 1));
        avg_upd_s   = tm_valid & (filled_r | last_slot_s);
        hi_exit_s   = sat_add(thr_high, -HYST_S);
        lo_exit_s   = sat_add(thr_low, HYST_S);
    end

    // Ring buffer, write pointer, running sum and fill flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                ring_r[i] <= 32'sd0;
            end
            ptr_r    <= '0;
            filled_r <= 1'b0;
            sum_r    <= '0;
        end else if (tm_valid) begin
            ring_r[ptr_r] <= tm_tempc;
            ptr_r         <= last_slot_s ? PTRW'(1'b0) : ptr_r + PTRW'(1'b1);
            sum_r         <= sum_nxt_s;
            if (last_slot_s) begin
                filled_r <= 1'b1;
            end
        end
    end

    // Registered average output; the shift floors toward negative infinity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_valid <= 1'b0;
            avg_tempc <= 32'sd0;
        end else begin
            avg_valid <= avg_upd_s;
            if (avg_upd_s) begin
                avg_tempc <= 32'(sum_nxt_s >>> AVG_LOG2);
            end
        end
    end

    // Alarm next-state and debounce counters; only an average update can move them.
    always_comb begin
        state_nxt_s  = state_r;
        hi_cnt_nxt_s = hi_cnt_r;
        lo_cnt_nxt_s = lo_cnt_r;
        ex_cnt_nxt_s = ex_cnt_r;
        if (avg_valid) begin
            case (state_r)
                ST_NORMAL: begin
                    hi_cnt_nxt_s = (avg_tempc > thr_high) ? sat_inc(hi_cnt_r) : 4'd0;
                    lo_cnt_nxt_s = (avg_tempc < thr_low) ? sat_inc(lo_cnt_r) : 4'd0;
                    ex_cnt_nxt_s = 4'd0;
                    // High has priority when both thresholds qualify together.
                    if (hi_cnt_nxt_s == DEB_C) begin
                        state_nxt_s  = ST_HIGH;
                        hi_cnt_nxt_s = 4'd0;
                        lo_cnt_nxt_s = 4'd0;
                    end else if (lo_cnt_nxt_s == DEB_C) begin
                        state_nxt_s  = ST_LOW;
                        hi_cnt_nxt_s = 4'd0;
                        lo_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_NORMAL;
                    end
                end
                ST_HIGH: begin
                    ex_cnt_nxt_s = (avg_tempc < hi_exit_s) ? sat_inc(ex_cnt_r) : 4'd0;
                    if (ex_cnt_nxt_s == DEB_C) begin
                        state_nxt_s  = ST_NORMAL;
                        ex_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    ex_cnt_nxt_s = (avg_tempc > lo_exit_s) ? sat_inc(ex_cnt_r) : 4'd0;
                    if (ex_cnt_nxt_s == DEB_C) begin
                        state_nxt_s  = ST_NORMAL;
                        ex_cnt_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_LOW;
                    end
                end
                default: begin
                    state_nxt_s  = ST_NORMAL;
                    hi_cnt_nxt_s = 4'd0;
                    lo_cnt_nxt_s = 4'd0;
                    ex_cnt_nxt_s = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s  = state_r;
            hi_cnt_nxt_s = hi_cnt_r;
            lo_cnt_nxt_s = lo_cnt_r;
            ex_cnt_nxt_s = ex_cnt_r;
        end
    end

    // State register with alarm outputs registered from the same next-state value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_NORMAL;
            hi_cnt_r   <= 4'd0;
            lo_cnt_r   <= 4'd0;
            ex_cnt_r   <= 4'd0;
            alarm_high <= 1'b0;
            alarm_low  <= 1'b0;
            tm_state   <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            hi_cnt_r   <= hi_cnt_nxt_s;
            lo_cnt_r   <= lo_cnt_nxt_s;
            ex_cnt_r   <= ex_cnt_nxt_s;
            alarm_high <= (state_nxt_s == ST_HIGH);
            alarm_low  <= (state_nxt_s == ST_LOW);
            tm_state   <= state_nxt_s;
        end
    end

`ifdef TEMP_MINMAX_EN
    logic mm_loaded_r;

    // Min/max of the published average; a clear coinciding with an update reloads from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_loaded_r <= 1'b0;
            tmin        <= 32'sd0;
            tmax        <= 32'sd0;
        end else if (avg_valid) begin
            if (clr_minmax || !mm_loaded_r) begin
                tmin        <= avg_tempc;
                tmax        <= avg_tempc;
                mm_loaded_r <= 1'b1;
            end else begin
                if (avg_tempc < tmin) begin
                    tmin <= avg_tempc;
                end
                if (avg_tempc > tmax) begin
                    tmax <= avg_tempc;
                end
            end
        end else if (clr_minmax) begin
            mm_loaded_r <= 1'b0;
            tmin        <= 32'sd0;
            tmax        <= 32'sd0;
        end
    end
`endif

endmodule

// File: tb/tb_temperature_monitor.sv
// Randomized and directed bench for temperature_monitor against a behavioural model
// built from sample windows and per-state histories of average updates.
module tb_temperature_monitor;

    localparam int WIN  = 4;
    localparam int D    = 3;
    localparam int HYST = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tm_valid;
    logic signed [31:0] tm_tempc, thr_high, thr_low;
    logic               avg_valid, alarm_high, alarm_low;
    logic signed [31:0] avg_tempc;
    logic [1:0]         tm_state;
    bit                 mm_clr;
`ifdef TEMP_MINMAX_EN
    logic               clr_minmax;
    logic signed [31:0] tmin, tmax;
    assign clr_minmax = mm_clr;
`endif

    int errors = 0;
    int checks = 0;

    temperature_monitor dut (
        .clk(clk), .rst_n(rst_n), .tm_valid(tm_valid), .tm_tempc(tm_tempc),
        .thr_high(thr_high), .thr_low(thr_low), .avg_valid(avg_valid),
        .avg_tempc(avg_tempc), .alarm_high(alarm_high), .alarm_low(alarm_low),
        .tm_state(tm_state)
`ifdef TEMP_MINMAX_EN
        , .clr_minmax(clr_minmax), .tmin(tmin), .tmax(tmax)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { longint avg; longint th; longint tl; } rec_t;
    longint win_q[$];
    rec_t   hist_q[$];
    bit     m_av;
    longint m_avg;
    int     m_state;
    bit     m_loaded;
    longint m_tmin, m_tmax;

    function automatic longint floor_div(longint s, longint n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic longint clamp32(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // True when the last D updates since the last state change all satisfy the rule.
    function automatic bit all_last(int kind);
        rec_t r;
        bit ok;
        if (hist_q.size() < D) return 1'b0;
        for (int i = hist_q.size() - D; i < hist_q.size(); i++) begin
            r = hist_q[i];
            case (kind)
                0: ok = r.avg > r.th;
                1: ok = r.avg < r.tl;
                2: ok = r.avg < clamp32(r.th - HYST);
                default: ok = r.avg > clamp32(r.tl + HYST);
            endcase
            if (!ok) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        win_q.delete(); hist_q.delete();
        m_av = 1'b0; m_avg = 0; m_state = 0;
        m_loaded = 1'b0; m_tmin = 0; m_tmax = 0;
    endfunction

    function automatic void model_edge(bit tv, longint tc);
        longint sum;
        if (m_av) begin
            hist_q.push_back('{m_avg, longint'(thr_high), longint'(thr_low)});
            if (m_state == 0) begin
                if (all_last(0)) begin m_state = 1; hist_q.delete(); end
                else if (all_last(1)) begin m_state = 2; hist_q.delete(); end
            end else if (m_state == 1) begin
                if (all_last(2)) begin m_state = 0; hist_q.delete(); end
            end else begin
                if (all_last(3)) begin m_state = 0; hist_q.delete(); end
            end
            while (hist_q.size() > D) void'(hist_q.pop_front());
            if (mm_clr || !m_loaded) begin m_tmin = m_avg; m_tmax = m_avg; m_loaded = 1'b1; end
            else begin
                if (m_avg < m_tmin) m_tmin = m_avg;
                if (m_avg > m_tmax) m_tmax = m_avg;
            end
        end else if (mm_clr) begin
            m_loaded = 1'b0; m_tmin = 0; m_tmax = 0;
        end
        m_av = 1'b0;
        if (tv) begin
            win_q.push_back(tc);
            if (win_q.size() > WIN) void'(win_q.pop_front());
            if (win_q.size() == WIN) begin
                sum = 0;
                foreach (win_q[i]) sum += win_q[i];
                m_av = 1'b1;
                m_avg = floor_div(sum, WIN);
            end
        end
    endfunction

    task automatic cycle(input bit tv, input longint tc);
        tm_valid = tv;
        tm_tempc = 32'(tc);
        @(posedge clk);
        model_edge(tv, longint'(tm_tempc));
        #1;
    endtask

    task automatic do_reset();
        tm_valid = 1'b0; tm_tempc = 32'sd0; mm_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid: got %0b want 0", avg_valid); end
        checks++; if (avg_tempc !== 32'sd0) begin errors++; $display("FAIL reset_avg_tempc: got %0d want 0", avg_tempc); end
        checks++; if (alarm_high !== 1'b0) begin errors++; $display("FAIL reset_alarm_high: got %0b want 0", alarm_high); end
        checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL reset_alarm_low: got %0b want 0", alarm_low); end
        checks++; if (tm_state !== 2'b00) begin errors++; $display("FAIL reset_tm_state: got %0d want 0", tm_state); end
    endtask

    task automatic test_fill();
        do_reset();
        thr_high = 32'sd1000; thr_low = -32'sd1000;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 100);
            checks++; if (avg_valid !== (i == 3)) begin errors++; $display("FAIL fill_valid[%0d]: got %0b want %0b", i, avg_valid, (i == 3)); end
        end
        checks++; if (avg_tempc !== 32'sd100) begin errors++; $display("FAIL fill_avg: got %0d want 100", avg_tempc); end
        cycle(1'b0, 0);
        checks++; if (avg_valid !== m_av) begin errors++; $display("FAIL fill_pulse: got %0b want %0b", avg_valid, m_av); end
    endtask

    task automatic test_average();
        cycle(1'b1, 104);
        checks++; if (avg_tempc !== 32'sd101) begin errors++; $display("FAIL avg_104: got %0d want 101", avg_tempc); end
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, -i);
        checks++; if (avg_tempc !== -32'sd3) begin errors++; $display("FAIL avg_floor: got %0d want -3", avg_tempc); end
        checks++; if (avg_tempc !== 32'(m_avg)) begin errors++; $display("FAIL avg_floor_model: got %0d want %0d", avg_tempc, m_avg); end
    endtask

    task automatic test_high_alarm();
        int seq[] = '{51, 51, 51, 51, 43, 59};
        do_reset();
        thr_high = 32'sd50; thr_low = -32'sd50;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 51);
            checks++; if (alarm_high !== 1'b0) begin errors++; $display("FAIL high_early[%0d]: got %0b want 0", i, alarm_high); end
        end
        cycle(1'b0, 0);
        checks++; if (alarm_high !== 1'b1 || tm_state !== 2'b01) begin errors++; $display("FAIL high_rise: got %0b/%0d want 1/1", alarm_high, tm_state); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(i < 6, (i < 6) ? seq[i] : 0);
            checks++; if (alarm_high !== 1'b0 || alarm_high !== (m_state == 1)) begin errors++; $display("FAIL high_broken[%0d]: got %0b want 0", i, alarm_high); end
        end
    endtask

    task automatic test_exit();
        do_reset();
        thr_high = 32'sd50; thr_low = -32'sd50;
        for (int i = 0; i < 6; i++) cycle(1'b1, 51);
        for (int i = 0; i < 4; i++) cycle(1'b1, 49);
        cycle(1'b0, 0);
        checks++; if (alarm_high !== 1'b1) begin errors++; $display("FAIL exit_hyst_hold: got %0b want 1", alarm_high); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 47);
            checks++; if (alarm_high !== (m_state == 1)) begin errors++; $display("FAIL exit_step[%0d]: got %0b want %0b", i, alarm_high, (m_state == 1)); end
        end
        cycle(1'b0, 0);
        checks++; if (alarm_high !== 1'b0 || tm_state !== 2'b00) begin errors++; $display("FAIL exit_normal: got %0b/%0d want 0/0", alarm_high, tm_state); end
    endtask

    task automatic test_priority();
        do_reset();
        thr_high = 32'sd0; thr_low = 32'sd10;
        for (int i = 0; i < 7; i++) begin
            cycle(i < 6, 5);
            checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL prio_low[%0d]: got %0b want 0", i, alarm_low); end
        end
        checks++; if (alarm_high !== 1'b1) begin errors++; $display("FAIL prio_high: got %0b want 1", alarm_high); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({avg_valid, alarm_high, alarm_low, tm_state} !== 5'b0 || avg_tempc !== 32'sd0) begin
            errors++; $display("FAIL async_reset: got %0b%0b%0b %0d %0d want all 0", avg_valid, alarm_high, alarm_low, tm_state, avg_tempc); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5);
            checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL refill[%0d]: got %0b want 0", i, avg_valid); end
        end
    endtask

    task automatic test_random();
        int mode;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) begin
                mode = $urandom_range(0, 7);
                if (mode == 0) begin thr_high = -32'sd2147483647; thr_low = 32'sd2147483646; end
                else if (mode == 1) begin thr_high = 32'sd2147483647; thr_low = 32'sd2147483646; end
                else begin
                    thr_high = 32'(int'($urandom_range(0, 40)) - 20);
                    thr_low  = 32'(int'($urandom_range(0, 40)) - 20);
                end
            end
            mm_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0)
                cycle(1'b1, ($urandom_range(0, 1) == 0) ? -64'sd2147483648 : 64'sd2147483647);
            else
                cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 80)) - 40);
            checks++; if (avg_valid !== m_av) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, avg_valid, m_av); end
            checks++; if (avg_tempc !== 32'(m_avg)) begin errors++; $display("FAIL rnd_avg@%0d: got %0d want %0d", n, avg_tempc, m_avg); end
            checks++; if (tm_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", n, tm_state, m_state); end
            checks++; if (alarm_high !== (m_state == 1) || alarm_low !== (m_state == 2)) begin
                errors++; $display("FAIL rnd_alarms@%0d: got %0b%0b want state %0d", n, alarm_high, alarm_low, m_state); end
`ifdef TEMP_MINMAX_EN
            checks++; if (tmin !== 32'(m_tmin) || tmax !== 32'(m_tmax)) begin
                errors++; $display("FAIL rnd_minmax@%0d: got %0d/%0d want %0d/%0d", n, tmin, tmax, m_tmin, m_tmax); end
`endif
        end
        mm_clr = 1'b0;
    endtask

`ifdef TEMP_MINMAX_EN
    task automatic test_minmax();
        int seq[] = '{10, 10, 10, 10, -110, 210};
        do_reset();
        thr_high = 32'sd1000; thr_low = -32'sd1000;
        foreach (seq[i]) cycle(1'b1, seq[i]);
        cycle(1'b1, -90);
        checks++; if (tmin !== -32'sd20 || tmax !== 32'sd30) begin errors++; $display("FAIL minmax_track: got %0d/%0d want -20/30", tmin, tmax); end
        checks++; if (avg_tempc !== 32'sd5) begin errors++; $display("FAIL minmax_avg5: got %0d want 5", avg_tempc); end
        mm_clr = 1'b1;
        cycle(1'b0, 0);
        mm_clr = 1'b0;
        checks++; if (tmin !== 32'sd5 || tmax !== 32'sd5) begin errors++; $display("FAIL minmax_clear: got %0d/%0d want 5/5", tmin, tmax); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; tm_valid = 1'b0; tm_tempc = 32'sd0; mm_clr = 1'b0;
        thr_high = 32'sd0; thr_low = 32'sd0;
        model_reset();
        test_reset();
        test_fill();
        test_average();
        test_high_alarm();
        test_exit();
        test_priority();
`ifdef TEMP_MINMAX_EN
        test_minmax();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
